// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared state encodings, widths and constants for the IF stage
package if_fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_TRAP  = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response channel (single outstanding)
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [XLEN-1:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry {pc,instr} holding register; clear has priority over load
module if_skid_buffer
   import if_fetch_unit_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic            full_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o
);

   logic            full_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] instr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q  <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else if (clear_i) begin
         full_q <= 1'b0;
      end else if (load_i) begin
         full_q  <= 1'b1;
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign full_o  = full_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, imem requests, skid buffer and IF/ID register
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect targets trap instead of being rounded down.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   if_fetch_unit_if.master imem,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instruction_o,
   output logic [XLEN-1:0] if_pc_plus4_o,
`ifdef IF_MISALIGN_CHECK_EN
   output logic            if_misaligned_o,
`endif
   output logic            if_valid_o
);

   fetch_state_e    state_q, state_d;
   fetch_state_e    land_redir, land_drain;
   logic [XLEN-1:0] pc_q, pc_d, target_q, target_d, redir_pc;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
   logic            ifid_valid_q, ifid_valid_d;
   logic            req_pending;
   logic            skid_load, skid_clear, skid_full;
   logic [XLEN-1:0] skid_pc, skid_instr;

   if_skid_buffer u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .pc_i    (pc_q),
      .instr_i (imem.rdata),
      .full_o  (skid_full),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

`ifdef IF_MISALIGN_CHECK_EN
   logic misal_q, misal_d;
   assign redir_pc        = redirect_pc_i;
   assign land_redir      = (redir_pc[1:0] != 2'b00) ? ST_TRAP : ST_FETCH;
   assign land_drain      = (target_q[1:0] != 2'b00) ? ST_TRAP : ST_FETCH;
   assign if_misaligned_o = misal_q;
`else
   assign redir_pc   = redirect_pc_i & ~32'h3;
   assign land_redir = ST_FETCH;
   assign land_drain = ST_FETCH;
`endif

   // DRAIN keeps the old address on the bus so an in-flight request is never retargeted
   assign req_pending = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign imem.req    = req_pending && !rst_i;
   assign imem.addr   = pc_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      skid_load    = 1'b0;
      skid_clear   = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      misal_d      = misal_q;
`endif
      if (redirect_i) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
         skid_clear   = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
         misal_d      = 1'b0;
`endif
         if (req_pending && !imem.ready) begin
            target_d = redir_pc;
            state_d  = ST_DRAIN;
         end else begin
            pc_d    = redir_pc;
            state_d = land_redir;
         end
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem.ready) begin
                  pc_d = pc_plus4(pc_q);
                  if (stall_i) begin
                     skid_load = 1'b1;
                     state_d   = ST_HOLD;
                  end else begin
                     ifid_pc_d    = pc_q;
                     ifid_instr_d = imem.rdata;
                     ifid_pc4_d   = pc_plus4(pc_q);
                     ifid_valid_d = 1'b1;
                  end
               end else if (!stall_i) begin
                  ifid_valid_d = 1'b0;
                  ifid_instr_d = NOP_INSTR;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  ifid_pc_d    = skid_pc;
                  ifid_instr_d = skid_full ? skid_instr : NOP_INSTR;
                  ifid_pc4_d   = pc_plus4(skid_pc);
                  ifid_valid_d = skid_full;
                  skid_clear   = 1'b1;
                  state_d      = ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (imem.ready) begin
                  pc_d    = target_q;
                  state_d = land_drain;
               end
            end
`ifdef IF_MISALIGN_CHECK_EN
            ST_TRAP: begin
               if (!stall_i) begin
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = NOP_INSTR;
                  ifid_pc4_d   = pc_plus4(pc_q);
                  ifid_valid_d = 1'b1;
                  misal_d      = 1'b1;
               end
            end
`endif
            default: state_d = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         target_q     <= RESET_PC;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) misal_q <= 1'b0;
      else       misal_q <= misal_d;
   end
`endif

   assign if_pc_o          = ifid_pc_q;
   assign if_instruction_o = ifid_instr_q;
   assign if_pc_plus4_o    = ifid_pc4_q;
   assign if_valid_o       = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector table, corner sequences and random run against a stream model
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] if_pc, if_instr, if_pc4;
   logic        if_valid;
`ifdef IF_MISALIGN_CHECK_EN
   logic        if_mis;
`endif

   if_fetch_unit_if imem_if();

   if_fetch_unit dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .stall_i          (stall),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .imem             (imem_if),
      .if_pc_o          (if_pc),
      .if_instruction_o (if_instr),
      .if_pc_plus4_o    (if_pc4),
`ifdef IF_MISALIGN_CHECK_EN
      .if_misaligned_o  (if_mis),
`endif
      .if_valid_o       (if_valid)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ {a[15:0], 16'h5A5A} ^ 32'h0000_0003;
   endfunction

   assign imem_if.rdata = mem_word(imem_if.addr);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: program-order stream with an optional parked word and an optional pending redirect
   typedef struct packed {logic [31:0] pc; logic [31:0] instr;} entry_t;
   entry_t      skidq[$];
   logic [31:0] drainq[$];
   logic [31:0] m_pc, m_ifpc, m_ifinstr, m_ifpc4;
   logic        m_ifvalid;
   bit          model_on = 1'b1;

   logic        s_req;
   logic [31:0] s_addr;
   logic        p_valid;
   logic [31:0] p_pc, p_instr, p_pc4;

   task automatic model_step(input logic r, s, rd, input logic [31:0] rp, input logic rdy);
      logic [31:0] word;
      logic [31:0] tgt;
      word = mem_word(m_pc);
      tgt  = rp & 32'hFFFF_FFFC;
      if (r) begin
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinstr = NOP; m_ifvalid = 1'b0;
         skidq.delete(); drainq.delete();
      end else if (rd) begin
         m_ifvalid = 1'b0; m_ifinstr = NOP;
         if (skidq.size() == 0 && !rdy) begin
            drainq.delete(); drainq.push_back(tgt);
         end else begin
            drainq.delete(); m_pc = tgt;
         end
         skidq.delete();
      end else if (skidq.size() != 0) begin
         if (!s) begin
            m_ifpc = skidq[0].pc; m_ifinstr = skidq[0].instr; m_ifpc4 = skidq[0].pc + 32'd4;
            m_ifvalid = 1'b1;
            skidq.delete();
         end
      end else if (drainq.size() != 0) begin
         if (rdy) m_pc = drainq.pop_front();
      end else if (rdy) begin
         if (s) skidq.push_back('{pc: m_pc, instr: word});
         else begin
            m_ifpc = m_pc; m_ifinstr = word; m_ifpc4 = m_pc + 32'd4; m_ifvalid = 1'b1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!s) begin
         m_ifvalid = 1'b0; m_ifinstr = NOP;
      end
   endtask

   task automatic cycle(input logic r, s, rd, input logic [31:0] rp, input logic rdy);
      logic exp_req;
      rst = r; stall = s; redirect = rd; redirect_pc = rp; imem_if.ready = rdy;
      #1;
      s_req  = imem_if.req;
      s_addr = imem_if.addr;
      if (model_on) begin
         exp_req = !r && (skidq.size() == 0);
         chk("model req", 32'(s_req), 32'(exp_req));
         if (exp_req) chk("model addr", s_addr, m_pc);
      end
      @(posedge clk);
      #1;
      p_valid = if_valid; p_pc = if_pc; p_instr = if_instr; p_pc4 = if_pc4;
      if (model_on) begin
         model_step(r, s, rd, rp, rdy);
         chk("model valid", 32'(p_valid), 32'(m_ifvalid));
         chk("model instr", p_instr, m_ifinstr);
         if (m_ifvalid) begin
            chk("model pc", p_pc, m_ifpc);
            chk("model pc4", p_pc4, m_ifpc4);
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic r, s, rd; logic [31:0] rp; logic rdy;
      logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, s, rd, input logic [31:0] rp, input logic rdy,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
      vec_t v;
      v.r = r; v.s = s; v.rd = rd; v.rp = rp; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      vecs.push_back(v);
   endtask

   initial begin
      logic        r, s, rd, rdy;
      logic [31:0] rp;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_if.ready = 1'b0;

      //   r  s  rd  rp            rdy  req addr          valid pc
      add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0);
      add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h0,          1, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h4,          1, 32'h4);
      add(0, 0, 0, 32'h0,          1,   1, 32'h8,          1, 32'h8);
      add(0, 0, 0, 32'h0,          1,   1, 32'hC,          1, 32'hC);
      add(0, 1, 0, 32'h0,          1,   1, 32'h10,         1, 32'hC);
      add(0, 1, 0, 32'h0,          1,   0, 32'h0,          1, 32'hC);
      add(0, 1, 0, 32'h0,          1,   0, 32'h0,          1, 32'hC);
      add(0, 0, 0, 32'h0,          1,   0, 32'h0,          1, 32'h10);
      add(0, 0, 0, 32'h0,          1,   1, 32'h14,         1, 32'h14);
      add(0, 0, 0, 32'h0,          0,   1, 32'h18,         0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h18,         1, 32'h18);
      add(0, 0, 0, 32'h0,          1,   1, 32'h1C,         1, 32'h1C);
      add(0, 0, 1, 32'h100,        0,   1, 32'h20,         0, 32'h0);
      add(0, 0, 0, 32'h0,          0,   1, 32'h20,         0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h20,         0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h100,        1, 32'h100);
      add(0, 1, 1, 32'h200,        1,   1, 32'h104,        0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'h200,        1, 32'h200);
      add(0, 0, 1, 32'hFFFF_FFF8,  1,   1, 32'h204,        0, 32'h0);
      add(0, 0, 0, 32'h0,          1,   1, 32'hFFFF_FFF8,  1, 32'hFFFF_FFF8);
      add(0, 0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC);
      add(0, 0, 0, 32'h0,          1,   1, 32'h0,          1, 32'h0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].r, vecs[i].s, vecs[i].rd, vecs[i].rp, vecs[i].rdy);
         chk($sformatf("vec%0d req", i), 32'(s_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req) chk($sformatf("vec%0d addr", i), s_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d valid", i), 32'(p_valid), 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d instr", i), p_instr, vecs[i].e_valid ? mem_word(vecs[i].e_pc) : NOP);
         if (vecs[i].r) begin
            chk($sformatf("vec%0d reset pc", i), p_pc, 32'h0);
            chk($sformatf("vec%0d reset pc4", i), p_pc4, 32'h0);
         end else if (vecs[i].e_valid) begin
            chk($sformatf("vec%0d pc", i), p_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d pc4", i), p_pc4, vecs[i].e_pc + 32'd4);
         end
      end

      // A second redirect while draining replaces the pending target
      cycle(1, 0, 0, 32'h0, 1);
      cycle(0, 0, 0, 32'h0, 1);
      cycle(0, 0, 1, 32'h300, 0);
      chk("drain addr held 1", s_addr, 32'h4);
      cycle(0, 0, 1, 32'h400, 0);
      chk("drain addr held 2", s_addr, 32'h4);
      chk("drain bubble", 32'(p_valid), 32'h0);
      cycle(0, 0, 0, 32'h0, 1);
      chk("drain addr held 3", s_addr, 32'h4);
      cycle(0, 0, 0, 32'h0, 1);
      chk("drain new target", s_addr, 32'h400);
      chk("drain new pc", p_pc, 32'h400);

      // Reset abandons an outstanding request
      cycle(0, 0, 0, 32'h0, 0);
      cycle(1, 0, 0, 32'h0, 0);
      chk("reset req low", 32'(s_req), 32'h0);
      cycle(0, 0, 0, 32'h0, 1);
      chk("post reset addr", s_addr, 32'h0);

      for (int k = 0; k < 4000; k++) begin
         r   = ($urandom_range(0, 299) == 0);
         s   = ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
         else                           rp = $urandom & 32'hFFFF_FFFC;
         cycle(r, s, rd, rp, rdy);
      end

      cycle(1, 0, 0, 32'h0, 1);
      cycle(0, 0, 0, 32'h0, 1);
`ifdef IF_MISALIGN_CHECK_EN
      model_on = 1'b0;
      cycle(0, 0, 1, 32'h102, 1);
      chk("trap entry valid", 32'(p_valid), 32'h0);
      cycle(0, 0, 0, 32'h0, 1);
      chk("trap req", 32'(s_req), 32'h0);
      chk("trap valid", 32'(p_valid), 32'h1);
      chk("trap misaligned", 32'(if_mis), 32'h1);
      chk("trap instr", p_instr, NOP);
      chk("trap pc", p_pc, 32'h102);
      chk("trap pc4", p_pc4, 32'h106);
      cycle(0, 0, 1, 32'h200, 1);
      chk("trap exit misaligned", 32'(if_mis), 32'h0);
      chk("trap exit valid", 32'(p_valid), 32'h0);
      cycle(0, 0, 0, 32'h0, 1);
      chk("trap resume req", 32'(s_req), 32'h1);
      chk("trap resume addr", s_addr, 32'h200);
`else
      cycle(0, 0, 1, 32'h102, 1);
      chk("misalign redirect bubble", 32'(p_valid), 32'h0);
      cycle(0, 0, 0, 32'h0, 1);
      chk("misalign rounded addr", s_addr, 32'h100);
      chk("misalign rounded pc", p_pc, 32'h100);
      chk("misalign rounded valid", 32'(p_valid), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
